// File: rtl/seq_mul_unit_pkg.sv
// seq_mul_unit_pkg: shared state encodings and default width for the sequential multiplier
package seq_mul_unit_pkg;
  localparam int DEF_WIDTH = 16;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
endpackage

// File: rtl/seq_mul_unit_ctrl.sv
// seq_mul_unit_ctrl: multiplier sequencer, one load, WIDTH steps, then one finish cycle
module seq_mul_unit_ctrl
  import seq_mul_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic load,
  output logic step,
  output logic finish,
  output logic busy
);
  logic [1:0] state, state_n;
  logic [CNT_W-1:0] cnt;
  logic last;
  always_comb begin
    last    = cnt == CNT_W'(WIDTH - 1);
    load    = state == S_IDLE && start;
    step    = state == S_RUN;
    finish  = state == S_FIN;
    busy    = step || finish;
    state_n = state == S_IDLE ? (start ? S_RUN : S_IDLE) :
              state == S_RUN  ? (last ? S_FIN : S_RUN) : S_IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= load ? '0 : step ? cnt + CNT_W'(1) : cnt;
    end
endmodule

// File: rtl/seq_mul_unit.sv
// seq_mul_unit: iterative shift-add multiplier on operand magnitudes, sign restored at the end
module seq_mul_unit
  import seq_mul_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);
  logic load, step, finish;
  logic [WIDTH-1:0] mcand, mplier, acc, abs_a, abs_b;
  logic neg, smode, ovf_n;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] mag, prod_n;
  seq_mul_unit_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ctrl (
    .clk(clk), .reset(reset), .start(start),
    .load(load), .step(step), .finish(finish), .busy(busy)
  );
  // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude
  always_comb begin
    abs_a  = signed_mode && op_a[WIDTH-1] ? -op_a : op_a;
    abs_b  = signed_mode && op_b[WIDTH-1] ? -op_b : op_b;
    sum    = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
    mag    = {acc, mplier};
    prod_n = neg ? -mag : mag;
    ovf_n  = smode ? prod_n[2*WIDTH-1:WIDTH] != {WIDTH{prod_n[WIDTH-1]}} : |prod_n[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      neg      <= 1'b0;
      smode    <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
      overflow <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        mcand  <= abs_a;
        mplier <= abs_b;
        acc    <= '0;
        neg    <= signed_mode && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        smode  <= signed_mode;
      end else if (step) begin
        acc    <= sum[WIDTH:1];
        mplier <= {sum[0], mplier[WIDTH-1:1]};
      end
      if (finish) begin
        product  <= prod_n;
        overflow <= ovf_n;
      end
    end
  assign result = product[WIDTH-1:0];
endmodule

// File: tb/tb_seq_mul_unit.sv
// tb_seq_mul_unit: directed and random checks of seq_mul_unit against arithmetic reference products
module tb_seq_mul_unit;
  logic clk = 0, reset = 0, start = 0, signed_mode = 0;
  logic [15:0] op_a = 0, op_b = 0, result;
  logic busy, done, overflow;
  logic [31:0] product;
  logic start8 = 0, sm8 = 0, busy8, done8, ovf8;
  logic [7:0] a8 = 0, b8 = 0, result8;
  logic [15:0] product8;
  int compared = 0, mismatched = 0;
  seq_mul_unit #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .product(product), .result(result), .overflow(overflow)
  );
  seq_mul_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
    .op_a(a8), .op_b(b8), .busy(busy8), .done(done8),
    .product(product8), .result(result8), .overflow(ovf8)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic longint ref_full(input logic sm, input logic [15:0] a, input logic [15:0] b);
    return sm ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
  endfunction
  function automatic logic [31:0] ref_prod(input logic sm, input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = ref_full(sm, a, b);
    return p[31:0];
  endfunction
  function automatic logic ref_ovf(input logic sm, input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = ref_full(sm, a, b);
    return sm ? (p < -32768 || p > 32767) : (p > 65535);
  endfunction
  task automatic launch(input logic sm, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    signed_mode = sm; op_a = a; op_b = b; start = 1;
    @(negedge clk);
    start = 0; signed_mode = 1'($urandom); op_a = 16'($urandom); op_b = 16'($urandom);
  endtask
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!done && n < 40);
  endtask
  task automatic expect_op(input string tag, input logic sm, input logic [15:0] a, input logic [15:0] b);
    int n;
    logic [31:0] p;
    wait_done(n);
    p = ref_prod(sm, a, b);
    check({tag, ".lat"}, n, 17);
    check({tag, ".prod"}, product, p);
    check({tag, ".res"}, result, p[15:0]);
    check({tag, ".ovf"}, overflow, ref_ovf(sm, a, b));
    check({tag, ".busy"}, busy, 0);
  endtask
  task automatic run(input string tag, input logic sm, input logic [15:0] a, input logic [15:0] b);
    launch(sm, a, b);
    expect_op(tag, sm, a, b);
    @(posedge clk); #1;
    check({tag, ".pulse"}, done, 0);
  endtask
  task automatic run8(input string tag, input logic sm, input logic [7:0] a, input logic [7:0] b);
    int n;
    longint p;
    @(negedge clk);
    sm8 = sm; a8 = a; b8 = b; start8 = 1;
    @(negedge clk);
    start8 = 0; a8 = 8'($urandom); b8 = 8'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!done8 && n < 30);
    p = sm ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
    check({tag, ".lat"}, n, 9);
    check({tag, ".prod"}, product8, p[15:0]);
    check({tag, ".ovf"}, ovf8, sm ? (p < -128 || p > 127) : (p > 255));
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, dones, first;
    logic sm;
    logic [15:0] a, b;
    #1 reset = 1;
    #12;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.prod", product, 0);
    check("rst.ovf", overflow, 0);
    @(negedge clk) reset = 0;
    run("s3x4", 1, 16'd3, 16'd4);
    check("s3x4.k", product, 32'h0000000C);
    run("s42x7", 1, 16'd42, 16'd7);
    check("s42x7.k", result, 16'd294);
    run("sm7xm2", 1, 16'hFFF9, 16'hFFFE);
    run("s26xm1", 1, 16'd26, 16'hFFFF);
    check("s26xm1.k", product, 32'hFFFFFFE6);
    run("s0x0", 1, 16'd0, 16'd0);
    run("s0x3", 1, 16'd0, 16'd3);
    run("s300sq", 1, 16'd300, 16'd300);
    check("s300sq.k", product, 32'h00015F90);
    check("s300sq.kovf", overflow, 1);
    run("smin1", 1, 16'h8000, 16'd1);
    check("smin1.k", result, 16'h8000);
    run("sminm1", 1, 16'h8000, 16'hFFFF);
    check("sminm1.k", product, 32'h00008000);
    check("sminm1.kovf", overflow, 1);
    run("uffsq", 0, 16'hFFFF, 16'hFFFF);
    check("uffsq.k", product, 32'hFFFE0001);
    run("uffx1", 0, 16'hFFFF, 16'd1);
    check("uffx1.kovf", overflow, 0);
    launch(0, 16'd7, 16'd9);
    dones = 0; first = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (first == 0) first = i;
      end
      start = (i == 3 || i == 10);
      op_a = 16'($urandom); op_b = 16'($urandom);
    end
    start = 0;
    check("ign.dones", dones, 1);
    check("ign.lat", first, 17);
    check("ign.prod", product, 32'd63);
    launch(1, 16'hFFFB, 16'd6);
    expect_op("b2b1", 1, 16'hFFFB, 16'd6);
    signed_mode = 0; op_a = 16'd1000; op_b = 16'd77; start = 1;
    @(posedge clk); #1;
    start = 0; op_a = 16'($urandom); op_b = 16'($urandom);
    check("b2b.hold", product, ref_prod(1, 16'hFFFB, 16'd6));
    expect_op("b2b2", 0, 16'd1000, 16'd77);
    launch(1, 16'd123, 16'd45);
    repeat (8) @(posedge clk);
    #2 reset = 1;
    #1;
    check("abort.prod", product, 0);
    check("abort.res", result, 0);
    check("abort.ovf", overflow, 0);
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    @(negedge clk) reset = 0;
    dones = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort.nodone", dones, 0);
    run("r5x5", 1, 16'd5, 16'd5);
    check("r5x5.k", product, 32'd25);
    for (int i = 0; i < 30; i++) begin
      sm = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
      if (i % 5 == 0) a = 16'h8000;
      run($sformatf("rnd%0d", i), sm, a, b);
    end
    run8("w8.minsq", 1, 8'h80, 8'h80);
    check("w8.minsq.k", product8, 16'h4000);
    check("w8.minsq.kovf", ovf8, 1);
    run8("w8.u", 0, 8'hFF, 8'hFF);
    for (int i = 0; i < 10; i++) run8($sformatf("w8rnd%0d", i), 1'($urandom), 8'($urandom), 8'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
